// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds an XNOR LFSR from the line, verifies it, then counts bit errors while locked.
// Latency: o_Error_Pulse and o_Locked are registered, one clock after the qualifying i_Data_DV cycle.
// Backpressure: none; every i_Data_DV cycle is consumed, and DV-low cycles freeze all checker state.
module prbs_checker #(
  parameter int                  NUM_BITS   = 7,
  parameter logic [NUM_BITS-1:0] TAPS       = 7'b1100000,
  parameter int                  LOCK_COUNT = 8,
  parameter int                  LOSS_COUNT = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Data_DV,
  input  logic        i_Data,
  input  logic        i_Clear_Count,
  output logic        o_Locked,
  output logic        o_Error_Pulse,
  output logic [15:0] o_Error_Count
);

  localparam logic [1:0] SEED   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int SEED_W  = $clog2(NUM_BITS + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);

  // Terminal values: the counter sits at *_LAST on the bit that completes the phase.
  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(NUM_BITS - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_COUNT - 1);

  logic [1:0]          r_State;
  logic [NUM_BITS-1:0] r_LFSR;
  logic [SEED_W-1:0]   r_Seed_Cnt;
  logic [MATCH_W-1:0]  r_Match_Cnt;
  logic [LOSS_W-1:0]   r_Loss_Cnt;

  logic                w_Predicted;
  logic                w_Mismatch;
  logic                w_Shift_Bit;
  logic [NUM_BITS-1:0] w_LFSR_Next;
  logic                w_Error;

  assign w_Predicted = ~^(r_LFSR & TAPS);
  assign w_Mismatch  = i_Data ^ w_Predicted;
  // Once locked, the register free-runs on its own prediction so a line error
  // corrupts only one compare instead of the next NUM_BITS predictions.
  assign w_Shift_Bit = (r_State == LOCKED) ? w_Predicted : i_Data;
  assign w_LFSR_Next = {r_LFSR[NUM_BITS-2:0], w_Shift_Bit};
  assign w_Error     = i_Data_DV && (r_State == LOCKED) && w_Mismatch;

  // Seed / verify / locked sequencing, LFSR shifting and the registered lock flag.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= SEED;
      r_LFSR      <= '0;
      r_Seed_Cnt  <= '0;
      r_Match_Cnt <= '0;
      r_Loss_Cnt  <= '0;
      o_Locked    <= 1'b0;
    end else if (i_Data_DV) begin
      r_LFSR <= w_LFSR_Next;
      case (r_State)
        SEED: begin
          if (r_Seed_Cnt == SEED_LAST) begin
            r_Seed_Cnt <= '0;
            // An all-ones seed is the XNOR lockup state: it would predict ones
            // forever, so throw it away and collect a fresh seed.
            if (!(&w_LFSR_Next)) begin
              r_State     <= VERIFY;
              r_Match_Cnt <= '0;
            end
          end else begin
            r_Seed_Cnt <= r_Seed_Cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (w_Mismatch) begin
            r_State    <= SEED;
            r_Seed_Cnt <= '0;
          end else if (r_Match_Cnt == MATCH_LAST) begin
            r_State     <= LOCKED;
            r_Match_Cnt <= '0;
            r_Loss_Cnt  <= '0;
            o_Locked    <= 1'b1;
          end else begin
            r_Match_Cnt <= r_Match_Cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (w_Mismatch) begin
            if (r_Loss_Cnt == LOSS_LAST) begin
              r_State    <= SEED;
              r_Seed_Cnt <= '0;
              r_Loss_Cnt <= '0;
              o_Locked   <= 1'b0;
            end else begin
              r_Loss_Cnt <= r_Loss_Cnt + 1'b1;
            end
          end else begin
            r_Loss_Cnt <= '0;
          end
        end
        default: begin
          r_State    <= SEED;
          r_Seed_Cnt <= '0;
          o_Locked   <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter; a clear request wins over a coincident error.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Error_Pulse <= 1'b0;
      o_Error_Count <= '0;
    end else begin
      o_Error_Pulse <= w_Error;
      if (i_Clear_Count) begin
        o_Error_Count <= '0;
      end else if (w_Error && (o_Error_Count != 16'hFFFF)) begin
        o_Error_Count <= o_Error_Count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (loss threshold 4 and 70000) share one stimulus stream.
// Each clock the outputs are compared with a bit-history reference model of the lock rules.
// Directed phases cover lock timing, single/burst errors, lockup seed, sparse DV and saturation.
module tb_prbs_checker;

  localparam int PH_SEED   = 0;
  localparam int PH_VERIFY = 1;
  localparam int PH_LOCKED = 2;

  logic i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic        i_Reset;
  logic        i_Data_DV;
  logic        i_Data;
  logic        i_Clear_Count;
  logic        lk_a, ep_a, lk_b, ep_b;
  logic [15:0] ec_a, ec_b;

  prbs_checker dut_a (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Data_DV(i_Data_DV), .i_Data(i_Data),
    .i_Clear_Count(i_Clear_Count), .o_Locked(lk_a), .o_Error_Pulse(ep_a), .o_Error_Count(ec_a)
  );

  prbs_checker #(.LOSS_COUNT(70000)) dut_b (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Data_DV(i_Data_DV), .i_Data(i_Data),
    .i_Clear_Count(i_Clear_Count), .o_Locked(lk_b), .o_Error_Pulse(ep_b), .o_Error_Count(ec_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: last 7 effective bits, oldest first; x^7+x^6+1 taps the two oldest.
  int m_phase[2];
  int m_n[2];
  int m_lim[2];
  int m_cnt[2];
  bit m_pulse[2];
  bit m_lock[2];
  bit m_hist[2][7];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_phase[u] = PH_SEED;
      m_n[u]     = 0;
      m_cnt[u]   = 0;
      m_pulse[u] = 1'b0;
      m_lock[u]  = 1'b0;
      for (int k = 0; k < 7; k++) m_hist[u][k] = 1'b0;
    end
  endtask

  task automatic model_step(input int u, input bit dv, input bit d, input bit clr);
    bit pred, b, miss, all_ones;
    m_pulse[u] = 1'b0;
    if (dv) begin
      pred = !(m_hist[u][0] ^ m_hist[u][1]);
      miss = (d != pred);
      b    = (m_phase[u] == PH_LOCKED) ? pred : d;
      for (int k = 0; k < 6; k++) m_hist[u][k] = m_hist[u][k+1];
      m_hist[u][6] = b;
      all_ones = 1'b1;
      for (int k = 0; k < 7; k++) if (!m_hist[u][k]) all_ones = 1'b0;
      case (m_phase[u])
        PH_SEED: begin
          m_n[u]++;
          if (m_n[u] == 7) begin
            m_n[u] = 0;
            if (!all_ones) m_phase[u] = PH_VERIFY;
          end
        end
        PH_VERIFY: begin
          if (miss) begin
            m_phase[u] = PH_SEED;
            m_n[u]     = 0;
          end else begin
            m_n[u]++;
            if (m_n[u] == 8) begin
              m_phase[u] = PH_LOCKED;
              m_n[u]     = 0;
            end
          end
        end
        default: begin
          if (miss) begin
            m_pulse[u] = 1'b1;
            m_n[u]++;
            if (m_n[u] == m_lim[u]) begin
              m_phase[u] = PH_SEED;
              m_n[u]     = 0;
            end
          end else begin
            m_n[u] = 0;
          end
        end
      endcase
    end
    if (clr) m_cnt[u] = 0;
    else if (m_pulse[u] && m_cnt[u] < 65535) m_cnt[u]++;
    m_lock[u] = (m_phase[u] == PH_LOCKED);
  endtask

  // Reference PRBS7 source (XNOR form, seed 0).
  bit [6:0] g;
  task automatic gen(output bit o);
    o = !(g[6] ^ g[5]);
    g = {g[5:0], o};
  endtask

  task automatic step(input bit dv, input bit d, input bit clr);
    @(negedge i_Clk);
    i_Data_DV     = dv;
    i_Data        = d;
    i_Clear_Count = clr;
    @(posedge i_Clk);
    #1;
    for (int u = 0; u < 2; u++) model_step(u, dv, d, clr);
    check("lock_a",  lk_a, m_lock[0]);
    check("pulse_a", ep_a, m_pulse[0]);
    check("count_a", ec_a, m_cnt[0]);
    check("lock_b",  lk_b, m_lock[1]);
    check("pulse_b", ep_b, m_pulse[1]);
    check("count_b", ec_b, m_cnt[1]);
  endtask

  // Reset is raised between clock edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge i_Clk);
    i_Reset       = 1'b1;
    i_Data_DV     = 1'b0;
    i_Clear_Count = 1'b0;
    #1;
    check("rst_lock_a",  lk_a, 0);
    check("rst_pulse_a", ep_a, 0);
    check("rst_count_a", ec_a, 0);
    check("rst_lock_b",  lk_b, 0);
    check("rst_pulse_b", ep_b, 0);
    check("rst_count_b", ec_b, 0);
    model_reset();
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    g = '0;
  endtask

  initial begin
    bit b;
    bit seen;
    int nvalid;
    int pulses;
    bit dv;

    i_Reset       = 1'b1;
    i_Data_DV     = 1'b0;
    i_Data        = 1'b0;
    i_Clear_Count = 1'b0;
    m_lim[0] = 4;
    m_lim[1] = 70000;
    model_reset();
    g = '0;
    repeat (3) @(posedge i_Clk);
    #1;
    check("init_lock_a",  lk_a, 0);
    check("init_count_a", ec_a, 0);
    check("init_pulse_a", ep_a, 0);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    // Idle after reset: random data without DV must not move anything.
    for (int i = 0; i < 30; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Clean stream: lock on the 15th bit, no pulses.
    seen = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 1000; i++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      if (ep_a) pulses++;
      if (!seen && lk_a) begin
        seen = 1'b1;
        check("lock_at", i, 15);
      end
    end
    check("lock_seen", seen, 1);
    check("clean_pulses", pulses, 0);

    // One inverted bit while locked.
    gen(b);
    step(1'b1, !b, 1'b0);
    check("single_pulse", ep_a, 1);
    check("single_count", ec_a, 1);
    check("single_lock",  lk_a, 1);
    gen(b);
    step(1'b1, b, 1'b0);
    check("single_pulse_end", ep_a, 0);
    step(1'b0, 1'b0, 1'b1);
    check("clear_count", ec_a, 0);

    // Burst of four inverted bits drops lock, clean data relocks after 15 bits.
    for (int i = 0; i < 4; i++) begin
      gen(b);
      step(1'b1, !b, 1'b0);
    end
    check("burst_count", ec_a, 4);
    check("burst_pulse", ep_a, 1);
    check("burst_unlock", lk_a, 0);
    check("burst_b_locked", lk_b, 1);
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      if (!seen && lk_a) begin
        seen = 1'b1;
        check("relock_at", i, 15);
      end
    end
    check("relock_seen", seen, 1);

    // Constant ones: every seed is the lockup pattern, never locks.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (lk_a) seen = 1'b1;
    end
    check("ones_never_lock", seen, 0);

    // Sparse DV (one cycle in three) on a clean stream.
    do_reset();
    seen = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 300; c++) begin
      dv = (c % 3 == 0);
      b  = 1'b0;
      if (dv) begin
        gen(b);
        nvalid++;
      end
      step(dv, b, 1'b0);
      if (!seen && lk_a) begin
        seen = 1'b1;
        check("sparse_lock_at", nvalid, 15);
      end
    end
    check("sparse_lock_seen", seen, 1);

    // Random mix of DV gaps, injected errors and clears.
    for (int c = 0; c < 3000; c++) begin
      dv = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      if (dv) begin
        gen(b);
        if ($urandom_range(0, 31) == 0) b = !b;
      end
      step(dv, b, ($urandom_range(0, 49) == 0));
    end

    // Saturation: inverted stream on the high-loss instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      gen(b);
      step(1'b1, b, 1'b0);
    end
    check("sat_locked_start", lk_b, 1);
    for (int i = 0; i < 66000; i++) begin
      gen(b);
      step(1'b1, !b, 1'b0);
    end
    check("sat_count", ec_b, 16'hFFFF);
    check("sat_pulse", ep_b, 1);
    check("sat_locked", lk_b, 1);
    do_reset();
    step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
